// File: rtl/pipe_ctrl_pkg.sv
// Shared processor-pipeline definitions: control FSM states, stage-register
// control words and the bubble/no-op constants used by the stage registers.
package pipe_ctrl_pkg;

    localparam int REG_W   = 3;
    localparam int STALL_W = 16;
    localparam int TMO_W   = 8;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_MEM_STALL = 2'd1,
        ST_HALTED    = 2'd2,
        ST_ERROR     = 2'd3
    } ctrlState_t;

    typedef struct packed {
        logic pcEn;
        logic ifidEn;
        logic idexEn;
        logic exmemEn;
        logic memwbEn;
        logic ifidFlush;
        logic idexFlush;
    } stageCtrl_t;

    localparam stageCtrl_t CTRL_FREEZE   = stageCtrl_t'(7'b00000_00);
    localparam stageCtrl_t CTRL_NORMAL   = stageCtrl_t'(7'b11111_00);
    localparam stageCtrl_t CTRL_REDIRECT = stageCtrl_t'(7'b11111_11);
    localparam stageCtrl_t CTRL_LOAD_USE = stageCtrl_t'(7'b00111_01);

    // A flushed stage register loads these: every control bit cleared.
    localparam logic [15:0] NOP_INSTR   = 16'h0000;
    localparam logic [7:0]  BUBBLE_CTRL = 8'h00;

    function automatic logic isActive(input ctrlState_t s);
        return (s == ST_RUN) || (s == ST_MEM_STALL);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/memory status from the datapath and stage-register controls back to it.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic               exMemRead;
    logic [REG_W-1:0]   exWriteReg;
    logic [REG_W-1:0]   idRs;
    logic [REG_W-1:0]   idRt;
    logic               idUsesRs;
    logic               idUsesRt;
    logic               branchTaken;
    logic               memBusy;
    logic               haltWB;

    logic               pcEn;
    logic               ifidEn;
    logic               idexEn;
    logic               exmemEn;
    logic               memwbEn;
    logic               ifidFlush;
    logic               idexFlush;
    logic               halted;
    logic               memErr;
    logic [STALL_W-1:0] stallCount;
    logic [1:0]         ctrlState;

    modport master (
        output exMemRead, exWriteReg, idRs, idRt, idUsesRs, idUsesRt,
               branchTaken, memBusy, haltWB,
        input  pcEn, ifidEn, idexEn, exmemEn, memwbEn, ifidFlush, idexFlush,
               halted, memErr, stallCount, ctrlState
    );

    modport slave (
        input  exMemRead, exWriteReg, idRs, idRt, idUsesRs, idUsesRt,
               branchTaken, memBusy, haltWB,
        output pcEn, ifidEn, idexEn, exmemEn, memwbEn, ifidFlush, idexFlush,
               halted, memErr, stallCount, ctrlState
    );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard: the ID/EX load writes a register the IF/ID instruction reads.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic             exMemRead,
    input  logic [REG_W-1:0] exWriteReg,
    input  logic [REG_W-1:0] idRs,
    input  logic [REG_W-1:0] idRt,
    input  logic             idUsesRs,
    input  logic             idUsesRt,
    output logic             loadUse
);

    assign loadUse = exMemRead & ((idUsesRs & (idRs == exWriteReg)) |
                                  (idUsesRt & (idRt == exWriteReg)));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stage enables/flushes, memory-stall timeout FSM, halt
// handling and a saturating stalled-cycle counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);

    ctrlState_t         state;
    logic [TMO_W-1:0]   tmoCnt;
    logic [TMO_W-1:0]   tmoNext;
    logic [STALL_W-1:0] stallCnt;
    logic               loadUse;
    stageCtrl_t         ctrl;

    hazard_detect u_hazard (
        .exMemRead  (bus.exMemRead),
        .exWriteReg (bus.exWriteReg),
        .idRs       (bus.idRs),
        .idRt       (bus.idRt),
        .idUsesRs   (bus.idUsesRs),
        .idUsesRt   (bus.idUsesRt),
        .loadUse    (loadUse)
    );

    // Reset gates the controls too, since the state alone reads as RUN.
    always_comb begin
        ctrl = CTRL_FREEZE;
        if (!rst || !isActive(state) || bus.memBusy) begin
            ctrl = CTRL_FREEZE;
        end else if (bus.branchTaken) begin
            ctrl = CTRL_REDIRECT;
        end else if (loadUse) begin
            ctrl = CTRL_LOAD_USE;
        end else begin
            ctrl = CTRL_NORMAL;
        end
    end

    assign tmoNext = tmoCnt + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_RUN;
            tmoCnt   <= '0;
            stallCnt <= '0;
        end else begin
            if (isActive(state) && !ctrl.pcEn && (stallCnt != '1)) begin
                stallCnt <= stallCnt + 1'b1;
            end
            unique case (state)
                ST_RUN: begin
                    if (bus.memBusy) begin
                        state  <= ST_MEM_STALL;
                        tmoCnt <= '0;
                    end else if (bus.haltWB) begin
                        state <= ST_HALTED;
                    end
                end
                ST_MEM_STALL: begin
                    // Comparing the incremented count makes the RUN cycle the first of N+1 busy cycles.
                    if (bus.memBusy) begin
                        if (tmoNext == TMO_W'(MEM_TIMEOUT)) begin
                            state  <= ST_ERROR;
                            tmoCnt <= '0;
                        end else begin
                            tmoCnt <= tmoNext;
                        end
                    end else begin
                        tmoCnt <= '0;
                        state  <= bus.haltWB ? ST_HALTED : ST_RUN;
                    end
                end
                ST_HALTED: state <= ST_HALTED;
                ST_ERROR:  state <= ST_ERROR;
                default:   state <= ST_RUN;
            endcase
        end
    end

    assign bus.pcEn       = ctrl.pcEn;
    assign bus.ifidEn     = ctrl.ifidEn;
    assign bus.idexEn     = ctrl.idexEn;
    assign bus.exmemEn    = ctrl.exmemEn;
    assign bus.memwbEn    = ctrl.memwbEn;
    assign bus.ifidFlush  = ctrl.ifidFlush;
    assign bus.idexFlush  = ctrl.idexFlush;
    assign bus.halted     = (state == ST_HALTED);
    assign bus.memErr     = (state == ST_ERROR);
    assign bus.stallCount = stallCnt;
    assign bus.ctrlState  = state;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: consecutive memBusy cycles tolerated before the error state; legal range 1..255.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 exMemRead  in  1  instruction in ID/EX is a load.
REQ-005 exWriteReg  in  3  destination register of the ID/EX instruction.
REQ-006 idRs, idRt  in  3 each  source registers of the IF/ID instruction.
REQ-007 idUsesRs, idUsesRt  in  1 each  IF/ID instruction reads Rs/Rt.
REQ-008 branchTaken  in  1  EX-stage redirect (branch taken or jump).
REQ-009 memBusy  in  1  data or instruction memory not ready this cycle.
REQ-010 haltWB  in  1  halt flag at the MEM/WB register output.
REQ-011 pcEn, ifidEn, idexEn, exmemEn, memwbEn  out  1 each  stage-register load enables.
REQ-012 ifidFlush, idexFlush  out  1 each  load a bubble (all controls zero) into that register.
REQ-013 halted  out  1  processor stopped by halt.
REQ-014 memErr  out  1  sticky memory-timeout error.
REQ-015 stallCount  out  16  saturating count of stalled cycles.
REQ-016 ctrlState  out  2  current state: 0 RUN, 1 MEM_STALL, 2 HALTED, 3 ERROR.

Function
REQ-017 The enable and flush outputs SHALL be combinational in the registered state and the current inputs; the state, the timeout counter and stallCount SHALL be registered.
REQ-018 Load-use hazard = exMemRead & ((idUsesRs & idRs==exWriteReg) | (idUsesRt & idRt==exWriteReg)).
REQ-019 Priority, highest first: HALTED/ERROR state, memBusy, branchTaken, load-use, normal.
REQ-020 HALTED or ERROR: all enables 0, all flushes 0.
REQ-021 memBusy=1 in RUN or MEM_STALL: all enables 0, all flushes 0, regardless of branchTaken or the hazard.
REQ-022 branchTaken=1 (no memBusy): all enables 1, ifidFlush=1, idexFlush=1; a simultaneous load-use hazard is ignored.
REQ-023 Load-use only: pcEn=0, ifidEn=0, idexEn=1, idexFlush=1, exmemEn=1, memwbEn=1.
REQ-024 Normal: all enables 1, all flushes 0.
REQ-025 Transitions: RUN->MEM_STALL on memBusy=1; MEM_STALL->RUN on memBusy=0; RUN or MEM_STALL->HALTED on haltWB=1 with memBusy=0; MEM_STALL->ERROR when the timeout counter equals MEM_TIMEOUT with memBusy still 1; HALTED and ERROR are exit-only-by-reset.
REQ-026 haltWB=1 while memBusy=1 SHALL be deferred until memBusy=0.
REQ-027 Timeout counter (8 bits): cleared on entering MEM_STALL and on leaving it, incremented each MEM_STALL cycle with memBusy=1.
REQ-028 With MEM_TIMEOUT=N and memBusy held high, ERROR is entered on the clock edge that ends the (N+1)th consecutive busy cycle (the RUN cycle plus N MEM_STALL cycles); memBusy dropping on the (N+1)th cycle returns to RUN.
REQ-029 stallCount increments by 1 in each cycle where pcEn=0 and the state is RUN or MEM_STALL, and saturates at 0xFFFF.
REQ-030 halted=1 exactly when ctrlState=HALTED; memErr=1 exactly when ctrlState=ERROR.

Reset
REQ-031 While rst=0: state RUN, timeout counter 0, stallCount 0, halted 0, memErr 0, and all enables and flushes forced to 0.
REQ-032 Reset asserted mid-stall or mid-halt SHALL return to RUN immediately, with no pending haltWB or timeout carried over.

Structure
REQ-033 State encodings and the bubble/no-op constants SHALL live in the shared processor package, for reuse by the stage registers.
REQ-034 Hazard comparison SHALL be one sub-module, hazard_detect (combinational); everything else is flat in pipe_ctrl.

Verification
REQ-035 exMemRead=1, exWriteReg=3, idRs=3, idUsesRs=1 -> pcEn=0, ifidEn=0, idexFlush=1 for one cycle; stallCount 0->1.
REQ-036 Same hazard plus branchTaken=1 -> all enables 1, ifidFlush=1, idexFlush=1, stallCount unchanged.
REQ-037 memBusy high for 4 cycles, MEM_TIMEOUT=15 -> all enables 0 for 4 cycles, ctrlState 1 then 0, stallCount +4, memErr 0.
REQ-038 memBusy held high for 16 cycles, MEM_TIMEOUT=15 -> ctrlState=3, memErr=1, remains so after memBusy drops, until rst=0.
REQ-039 haltWB=1 with memBusy=1 for 2 cycles, then memBusy=0 -> HALTED entered on the edge after memBusy falls; halted=1, enables 0, stallCount frozen.
REQ-040 Apply rst=0 asynchronously during MEM_STALL -> outputs reset immediately without a clock edge; after release, normal enables resume.
